// File: rtl/rv32i_pkg.sv
// Shared RV32I core constants: default datapath widths and writeback requester numbering.
package rv32i_pkg;

  localparam int WORD_WTH_DEF    = 32;
  localparam int REG_INX_WTH_DEF = 5;
  localparam int REG_NUM_DEF     = 32;
  localparam int REQ_NUM_DEF     = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  // Width of a pointer into n requesters; never zero so single-requester builds stay legal.
  function automatic int ptr_wth(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32i_wbck_sched_if.sv
// Writeback request bus between the execution units (master) and the writeback scheduler (slave).
// Handshake: a requester raises req_valid[n] with stable req_idx/req_dat slice n and holds all three
// until req_ready[n] is seen high at a rising edge; valid&&ready at that edge is the transfer.
interface rv32i_wbck_sched_if
  import rv32i_pkg::*;
#(
  parameter int WORD_WTH    = WORD_WTH_DEF,
  parameter int REG_INX_WTH = REG_INX_WTH_DEF,
  parameter int REQ_NUM     = REQ_NUM_DEF
);

  logic [REQ_NUM-1:0]             req_valid;
  logic [REQ_NUM-1:0]             req_ready;
  logic [REQ_NUM*REG_INX_WTH-1:0] req_idx;
  logic [REQ_NUM*WORD_WTH-1:0]    req_dat;

  modport master (output req_valid, output req_idx, output req_dat, input req_ready);
  modport slave  (input req_valid, input req_idx, input req_dat, output req_ready);

endinterface

// File: rtl/rv32i_rr_arb.sv
// Combinational round-robin arbiter: first valid requester at or after ptr, wrapping modulo N.
module rv32i_rr_arb
  import rv32i_pkg::*;
#(
  parameter int N       = REQ_NUM_DEF,
  parameter int PTR_WTH = ptr_wth(N)
) (
  input  logic [N-1:0]       valid,
  input  logic [PTR_WTH-1:0] ptr,
  output logic [N-1:0]       grant
);

  int               kk;
  logic [PTR_WTH-1:0] k;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    kk    = 0;
    k     = '0;
    for (int off = 0; off < N; off++) begin
      kk = int'(ptr) + off;
      if (kk >= N) kk = kk - N;
      k = PTR_WTH'(kk);
      if (!found && valid[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32i_wbck_sched.sv
// Writeback scheduler: arbitrates execution-unit results onto the single regfile write port
// and tracks pending destinations so issue can stall on read-after-write hazards.
module rv32i_wbck_sched
  import rv32i_pkg::*;
#(
  parameter int WORD_WTH    = WORD_WTH_DEF,
  parameter int REG_INX_WTH = REG_INX_WTH_DEF,
  parameter int REG_NUM     = REG_NUM_DEF,
  parameter int REQ_NUM     = REQ_NUM_DEF,
  parameter int PTR_WTH     = ptr_wth(REQ_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  rv32i_wbck_sched_if.slave      req,
  output logic                   wbck_dest_wen,
  output logic [REG_INX_WTH-1:0] wbck_dest_idx,
  output logic [WORD_WTH-1:0]    wbck_dest_dat,
  input  logic                   sb_set_en,
  input  logic [REG_INX_WTH-1:0] sb_set_idx,
  input  logic [REG_INX_WTH-1:0] chk_src1_idx,
  input  logic [REG_INX_WTH-1:0] chk_src2_idx,
  output logic                   chk_src1_busy,
  output logic                   chk_src2_busy,
  output logic [PTR_WTH-1:0]     dbg_rr_ptr
);

  logic [PTR_WTH-1:0]     rr_ptr;
  logic [PTR_WTH-1:0]     rr_ptr_nxt;
  logic [PTR_WTH-1:0]     gnt_inx;
  logic [REQ_NUM-1:0]     gnt;
  logic [REQ_NUM-1:0]     ready;
  logic                   gnt_any;
  logic [REG_INX_WTH-1:0] sel_idx;
  logic [WORD_WTH-1:0]    sel_dat;

  logic [REG_NUM-1:1]     pending;
  logic [REG_NUM-1:0]     pend_full;
  logic [REG_NUM-1:0]     set_vec;
  logic [REG_NUM-1:0]     clr_vec;
  logic [REG_NUM-1:0]     pend_nxt;

  rv32i_rr_arb #(
    .N       (REQ_NUM),
    .PTR_WTH (PTR_WTH)
  ) u_arb (
    .valid (req.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt)
  );

  // No grant while reset is held, so nothing in flight can reach the regfile.
  assign ready         = rst ? gnt : '0;
  assign req.req_ready = ready;
  assign dbg_rr_ptr    = rr_ptr;

  always_comb begin
    gnt_any = 1'b0;
    gnt_inx = '0;
    sel_idx = '0;
    sel_dat = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (ready[i]) begin
        gnt_any = 1'b1;
        gnt_inx = PTR_WTH'(i);
        sel_idx = req.req_idx[i*REG_INX_WTH +: REG_INX_WTH];
        sel_dat = req.req_dat[i*WORD_WTH +: WORD_WTH];
      end
    end
  end

  assign rr_ptr_nxt = (gnt_inx == PTR_WTH'(REQ_NUM - 1)) ? '0 : gnt_inx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // x0 writes still consume the grant but never pulse the regfile enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wbck_dest_wen <= 1'b0;
      wbck_dest_idx <= '0;
      wbck_dest_dat <= '0;
    end else begin
      wbck_dest_wen <= gnt_any && (sel_idx != '0);
      if (gnt_any) begin
        wbck_dest_idx <= sel_idx;
        wbck_dest_dat <= sel_dat;
      end
    end
  end

  // Set is applied after clear so a re-issue of the register being written keeps it pending.
  always_comb begin
    pend_full = {pending, 1'b0};
    set_vec   = sb_set_en ? ({{(REG_NUM-1){1'b0}}, 1'b1} << sb_set_idx) : '0;
    clr_vec   = wbck_dest_wen ? ({{(REG_NUM-1){1'b0}}, 1'b1} << wbck_dest_idx) : '0;
    pend_nxt  = (pend_full & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pend_nxt[REG_NUM-1:1];
    end
  end

  // A write landing this cycle is forwarded by the regfile, so it no longer counts as busy.
  assign chk_src1_busy = pend_full[chk_src1_idx] &
                         ~(wbck_dest_wen && (wbck_dest_idx == chk_src1_idx));
  assign chk_src2_busy = pend_full[chk_src2_idx] &
                         ~(wbck_dest_wen && (wbck_dest_idx == chk_src2_idx));

endmodule

// File: tb/tb_rv32i_wbck_sched.sv
// Self-checking bench for rv32i_wbck_sched: directed scenarios plus random traffic against a reference model.
module tb_rv32i_wbck_sched;
  import rv32i_pkg::*;

  localparam int W  = 32;
  localparam int IW = 5;
  localparam int RN = 32;
  localparam int QN = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_wbck_sched_if #(.WORD_WTH(W), .REG_INX_WTH(IW), .REQ_NUM(QN)) ifc ();

  logic [QN-1:0] d_valid;
  logic [IW-1:0] d_idx [QN];
  logic [W-1:0]  d_dat [QN];
  logic          sb_set_en;
  logic [IW-1:0] sb_set_idx;
  logic [IW-1:0] c1_idx, c2_idx;
  logic          wen;
  logic [IW-1:0] widx;
  logic [W-1:0]  wdat;
  logic          busy1, busy2;
  logic [1:0]    dbg_ptr;

  assign ifc.req_valid = d_valid;
  assign ifc.req_idx   = {d_idx[2], d_idx[1], d_idx[0]};
  assign ifc.req_dat   = {d_dat[2], d_dat[1], d_dat[0]};

  rv32i_wbck_sched #(.WORD_WTH(W), .REG_INX_WTH(IW), .REG_NUM(RN), .REQ_NUM(QN)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (ifc),
    .wbck_dest_wen (wen),
    .wbck_dest_idx (widx),
    .wbck_dest_dat (wdat),
    .sb_set_en     (sb_set_en),
    .sb_set_idx    (sb_set_idx),
    .chk_src1_idx  (c1_idx),
    .chk_src2_idx  (c2_idx),
    .chk_src1_busy (busy1),
    .chk_src2_busy (busy2),
    .dbg_rr_ptr    (dbg_ptr)
  );

  // reference model state (values visible after the most recent edge)
  int            m_ptr;
  bit            m_pend [RN];
  logic          m_wen;
  logic [IW-1:0] m_idx;
  logic [W-1:0]  m_dat;
  logic [IW+W-1:0] exp_q [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    d_valid    = '0;
    sb_set_en  = 1'b0;
    sb_set_idx = '0;
    c1_idx     = '0;
    c2_idx     = '0;
    for (int k = 0; k < QN; k++) begin
      d_idx[k] = '0;
      d_dat[k] = '0;
    end
  endtask

  function automatic int model_grant();
    if (rst !== 1'b1) return -1;
    for (int off = 0; off < QN; off++) begin
      if (d_valid[(m_ptr + off) % QN]) return (m_ptr + off) % QN;
    end
    return -1;
  endfunction

  function automatic logic busy_exp(input logic [IW-1:0] s);
    if (s == 0) return 1'b0;
    return m_pend[s] && !(m_wen && (m_idx == s));
  endfunction

  // One clock: entered at posedge+1 with inputs driven; checks at posedge+3, then advances the model.
  task automatic run_cycle(output int g);
    logic [QN-1:0]   er;
    logic [IW+W-1:0] ent;
    #2;
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("ready", 64'(ifc.req_ready), 64'(er));
    check("wen",   64'(wen),   64'(m_wen));
    check("idx",   64'(widx),  64'(m_idx));
    check("dat",   64'(wdat),  64'(m_dat));
    check("ptr",   64'(dbg_ptr), 64'(m_ptr));
    check("busy1", 64'(busy1), 64'(busy_exp(c1_idx)));
    check("busy2", 64'(busy2), 64'(busy_exp(c2_idx)));
    if (wen === 1'b1) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        check("sb_write", 64'({widx, wdat}), 64'(ent));
      end
    end
    if (rst !== 1'b1) begin
      m_ptr = 0;
      for (int r = 0; r < RN; r++) m_pend[r] = 1'b0;
      m_wen = 1'b0;
      m_idx = '0;
      m_dat = '0;
      exp_q.delete();
    end else begin
      if (m_wen) m_pend[m_idx] = 1'b0;
      if (sb_set_en && sb_set_idx != 0) m_pend[sb_set_idx] = 1'b1;
      if (g >= 0) begin
        m_wen = (d_idx[g] != 0);
        m_idx = d_idx[g];
        m_dat = d_dat[g];
        m_ptr = (g + 1) % QN;
        if (m_wen) exp_q.push_back({m_idx, m_dat});
      end else begin
        m_wen = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b0;
    clear_inputs();
    run_cycle(g);
    rst = 1'b1;
  endtask

  initial begin
    int g;
    rst = 1'b0;
    clear_inputs();
    m_ptr = 0;
    for (int r = 0; r < RN; r++) m_pend[r] = 1'b0;
    m_wen = 1'b0;
    m_idx = '0;
    m_dat = '0;
    @(posedge clk);
    #1;
    do_reset();

    // all three requesters held valid: grants rotate 0,1,2,0
    d_valid = 3'b111;
    for (int k = 0; k < QN; k++) begin
      d_idx[k] = IW'(k + 1);
      d_dat[k] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      run_cycle(g);
      check("rr_grant", 64'(g), 64'(i % 3));
      check("rr_idx_seq", 64'(widx), 64'(i % 3 + 1));
    end
    clear_inputs();
    run_cycle(g);

    // pending x5 cleared by LSU write, bypassed during the write cycle
    do_reset();
    sb_set_en = 1'b1; sb_set_idx = 5'd5; c1_idx = 5'd5;
    run_cycle(g);
    sb_set_en = 1'b0;
    d_valid = 3'b010; d_idx[REQ_LSU] = 5'd5; d_dat[REQ_LSU] = 32'hDEADBEEF;
    #1 check("x5_busy_before", 64'(busy1), 64'd1);
    run_cycle(g);
    d_valid = '0;
    #1 check("x5_wen", 64'(wen), 64'd1);
    check("x5_dat", 64'(wdat), 64'hDEADBEEF);
    check("x5_busy_bypass", 64'(busy1), 64'd0);
    run_cycle(g);
    #1 check("x5_busy_after", 64'(busy1), 64'd0);
    run_cycle(g);

    // set and clear of x7 in the same cycle: set wins
    do_reset();
    sb_set_en = 1'b1; sb_set_idx = 5'd7; c1_idx = 5'd7;
    run_cycle(g);
    sb_set_en = 1'b0;
    d_valid = 3'b001; d_idx[REQ_ALU] = 5'd7; d_dat[REQ_ALU] = $urandom;
    run_cycle(g);
    d_valid = '0;
    sb_set_en = 1'b1; sb_set_idx = 5'd7;
    #1 check("x7_wen", 64'(wen), 64'd1);
    run_cycle(g);
    sb_set_en = 1'b0;
    #1 check("x7_busy_kept", 64'(busy1), 64'd1);
    run_cycle(g);

    // x0 write completes handshake without enable; x0 never pending
    do_reset();
    d_valid = 3'b001; d_idx[REQ_ALU] = 5'd0; d_dat[REQ_ALU] = 32'h1234;
    sb_set_en = 1'b1; sb_set_idx = 5'd0;
    #1 check("x0_ready", 64'(ifc.req_ready), 64'b001);
    run_cycle(g);
    clear_inputs();
    #1 check("x0_wen", 64'(wen), 64'd0);
    check("x0_busy", 64'(busy1), 64'd0);
    run_cycle(g);

    // reset mid-operation discards the MDU request and clears pending x9
    do_reset();
    sb_set_en = 1'b1; sb_set_idx = 5'd9;
    run_cycle(g);
    sb_set_en = 1'b0;
    d_valid = 3'b001; d_idx[REQ_ALU] = 5'd3; d_dat[REQ_ALU] = $urandom;
    run_cycle(g);
    d_valid = 3'b100; d_idx[REQ_MDU] = 5'd9; d_dat[REQ_MDU] = $urandom;
    rst = 1'b0;
    #1 check("rst_ready", 64'(ifc.req_ready), 64'd0);
    run_cycle(g);
    rst = 1'b1;
    clear_inputs();
    c1_idx = 5'd9;
    #1 check("rst_wen", 64'(wen), 64'd0);
    check("rst_busy9", 64'(busy1), 64'd0);
    check("rst_ptr", 64'(dbg_ptr), 64'd0);
    run_cycle(g);

    // MDU alone for four cycles: back-to-back writes, pointer wraps to 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d_valid = 3'b100; d_idx[REQ_MDU] = IW'(10 + i); d_dat[REQ_MDU] = $urandom;
      run_cycle(g);
      check("mdu_ptr", 64'(dbg_ptr), 64'd0);
      check("mdu_wen", 64'(wen), 64'd1);
      check("mdu_idx", 64'(widx), 64'(10 + i));
    end
    clear_inputs();
    run_cycle(g);

    // random traffic; requesters hold until granted
    g = -1;
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < QN; k++) begin
        if (g == k || !d_valid[k]) begin
          d_valid[k] = ($urandom_range(0, 2) != 0);
          d_idx[k]   = IW'($urandom_range(0, 31));
          d_dat[k]   = $urandom;
        end
      end
      sb_set_en  = ($urandom_range(0, 1) != 0);
      sb_set_idx = IW'($urandom_range(0, 31));
      c1_idx     = IW'($urandom_range(0, 31));
      c2_idx     = IW'($urandom_range(0, 31));
      rst        = ($urandom_range(0, 63) != 0);
      run_cycle(g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
